pipe_ctl_fsm_p: RTL and testbench

PIPE_CTL_FSM_P -- requirements
Module: pipe_ctl_fsm_p

---
 rtl/pipe_ctl_fsm_p.sv | 118 +++++++++++
 tb/tb_pipe_ctl_fsm_p.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_ctl_fsm_p.sv
// pipe_ctl_fsm_p: pipeline control FSM with multi-cycle MUL/LD stalls and prioritised interrupt entry.
module pipe_ctl_fsm_p #(
   parameter int MUL_LAT = 33,
   parameter int LD_LAT = 1,
   parameter int NIRQ = 4,
   localparam int IW = $clog2(NIRQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pause,
   input  logic [2:0]      id_cmd,
   input  logic [NIRQ-1:0] irq,
   input  logic [NIRQ-1:0] irq_mask,
   output logic            iack,
   output logic [IW-1:0]   irq_id,
   output logic            zz_is_nop,
   output logic            id2ra_ins_clr,
   output logic            id2ra_ins_cls,
   output logic            id2ra_ctl_clr,
   output logic            id2ra_ctl_cls,
   output logic            ra2exec_ctl_clr,
   output logic [3:0]      pc_prectl,
   output logic            busy
);
   // 4-bit encoding leaves spare codes so a corrupted register decodes as illegal
   typedef enum logic [3:0] {
      S_RST, S_IDLE, S_NOI, S_CUR, S_MUL, S_LD, S_IRQ, S_RET
   } state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic iack_q, iack_d, take;
   logic [IW-1:0] irq_id_q, win;
   logic [NIRQ-1:0] pend;

   assign iack = (state_q == S_IRQ) | (iack_q & (state_q != S_RET));
   assign iack_d = (state_q == S_IRQ) ? 1'b1 : (state_q == S_RET) ? 1'b0 : iack_q;
   assign pend = irq & irq_mask & ~{NIRQ{iack}};
   assign take = ((state_q == S_IDLE) | (state_q == S_NOI)) & (|pend);
   assign busy = (state_q == S_MUL) | (state_q == S_LD);
   assign irq_id = irq_id_q;

   always_comb begin
      win = '0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (pend[i]) win = IW'(i);
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE, S_NOI:
            if (take) state_d = S_IRQ;
            else case (id_cmd)
               3'd1: state_d = S_NOI;
               3'd2: state_d = S_CUR;
               3'd3: state_d = S_MUL;
               3'd4: state_d = S_LD;
               3'd5: state_d = S_RET;
               default: state_d = S_IDLE;
            endcase
         S_CUR: state_d = S_NOI;
         S_MUL: state_d = (cnt_q == 8'(MUL_LAT - 1)) ? S_IDLE : S_MUL;
         S_LD: state_d = (cnt_q == 8'(LD_LAT - 1)) ? S_IDLE : S_LD;
         default: state_d = S_IDLE;
      endcase
      cnt_d = (busy && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
   end

   always_comb begin
      id2ra_ins_clr = 1'b1;
      id2ra_ins_cls = 1'b0;
      id2ra_ctl_clr = 1'b1;
      id2ra_ctl_cls = 1'b0;
      ra2exec_ctl_clr = 1'b1;
      pc_prectl = 4'd3;
      zz_is_nop = 1'b1;
      case (state_q)
         S_IDLE, S_NOI, S_RET: begin
            id2ra_ins_clr = 1'b0;
            id2ra_ctl_clr = 1'b0;
            ra2exec_ctl_clr = 1'b0;
            pc_prectl = 4'd0;
            zz_is_nop = 1'b0;
         end
         S_CUR: begin
            id2ra_ins_clr = 1'b0;
            id2ra_ins_cls = 1'b1;
            id2ra_ctl_clr = 1'b0;
            id2ra_ctl_cls = 1'b1;
            pc_prectl = 4'd1;
         end
         S_MUL, S_LD: begin
            ra2exec_ctl_clr = 1'b0;
            pc_prectl = 4'd1;
            zz_is_nop = 1'b0;
         end
         S_IRQ: begin
            pc_prectl = 4'd2;
            zz_is_nop = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state_q <= S_RST;
         cnt_q <= '0;
         iack_q <= 1'b0;
         irq_id_q <= '0;
      end else if (!pause) begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         iack_q <= iack_d;
         if (take) irq_id_q <= win;
      end
endmodule

// File: tb/tb_pipe_ctl_fsm_p.sv
// tb_pipe_ctl_fsm_p: directed scoreboard bench checking per-cycle strobes, PC control, busy and interrupt status.
module tb_pipe_ctl_fsm_p;
   typedef enum {E_RST, E_IDLE, E_NOI, E_CUR, E_MUL, E_LD, E_IRQ, E_RET} st_e;
   typedef struct {
      string tag;
      logic [13:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1, pause = 1'b0;
   logic [2:0] id_cmd = 3'd0;
   logic [3:0] irq = 4'd0, irq_mask = 4'd0;
   logic iack, zz_is_nop, ins_clr, ins_cls, ctl_clr, ctl_cls, ra_clr, busy;
   logic [1:0] irq_id;
   logic [3:0] pc_prectl;
   exp_t sb[$];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   pipe_ctl_fsm_p #(.MUL_LAT(33), .LD_LAT(3), .NIRQ(4)) dut (
      .clk(clk), .rst(rst), .pause(pause), .id_cmd(id_cmd), .irq(irq), .irq_mask(irq_mask),
      .iack(iack), .irq_id(irq_id), .zz_is_nop(zz_is_nop), .id2ra_ins_clr(ins_clr),
      .id2ra_ins_cls(ins_cls), .id2ra_ctl_clr(ctl_clr), .id2ra_ctl_cls(ctl_cls),
      .ra2exec_ctl_clr(ra_clr), .pc_prectl(pc_prectl), .busy(busy)
   );

   // {ins_clr, ins_cls, ctl_clr, ctl_cls, ra2exec_clr, pc_prectl, zz_is_nop, busy, iack, irq_id}
   function automatic logic [13:0] expv(st_e e, logic ik, logic [1:0] id);
      logic [9:0] o;
      case (e)
         E_CUR: o = 10'b0_1_0_1_1_0001_1;
         E_MUL, E_LD: o = 10'b1_0_1_0_0_0001_0;
         E_IRQ: o = 10'b1_0_1_0_1_0010_0;
         E_RST: o = 10'b1_0_1_0_1_0011_1;
         default: o = 10'b0;
      endcase
      return {o, e == E_MUL || e == E_LD, ik, id};
   endfunction

   task automatic cyc(input st_e e, input logic ik, input logic [1:0] id, input string tag);
      exp_t t;
      logic [13:0] obs;
      sb.push_back('{tag, expv(e, ik, id)});
      @(posedge clk);
      #1;
      t = sb.pop_front();
      obs = {ins_clr, ins_cls, ctl_clr, ctl_cls, ra_clr, pc_prectl, zz_is_nop, busy, iack, irq_id};
      n_chk++;
      assert (obs === t.v) n_pass++;
      else $error("FAIL %s: got %b want %b", t.tag, obs, t.v);
   endtask

   initial begin
      cyc(E_RST, 0, 0, "rst0");
      cyc(E_RST, 0, 0, "rst1");
      rst = 0;
      cyc(E_IDLE, 0, 0, "rel_idle");
      cyc(E_IDLE, 0, 0, "idle_hold");
      id_cmd = 1; cyc(E_NOI, 0, 0, "noi");
      cyc(E_NOI, 0, 0, "noi_noi");
      id_cmd = 2; cyc(E_CUR, 0, 0, "cur");
      id_cmd = 0; cyc(E_NOI, 0, 0, "cur_noi");
      cyc(E_IDLE, 0, 0, "noi_idle");
      id_cmd = 6; cyc(E_IDLE, 0, 0, "cmd6");
      id_cmd = 7; cyc(E_IDLE, 0, 0, "cmd7");
      id_cmd = 5; cyc(E_RET, 0, 0, "ret_noack");
      id_cmd = 0; cyc(E_IDLE, 0, 0, "ret_idle");
      id_cmd = 3; cyc(E_MUL, 0, 0, "mul_in");
      id_cmd = 0;
      for (int i = 1; i < 33; i++) cyc(E_MUL, 0, 0, "mul");
      cyc(E_IDLE, 0, 0, "mul_out");
      id_cmd = 3; cyc(E_MUL, 0, 0, "pmul_in");
      id_cmd = 0;
      for (int i = 1; i < 10; i++) cyc(E_MUL, 0, 0, "pmul_a");
      pause = 1;
      for (int i = 0; i < 5; i++) cyc(E_MUL, 0, 0, "pmul_paused");
      pause = 0;
      for (int i = 0; i < 23; i++) cyc(E_MUL, 0, 0, "pmul_b");
      cyc(E_IDLE, 0, 0, "pmul_out");
      id_cmd = 4; cyc(E_LD, 0, 0, "ld_in");
      id_cmd = 0; cyc(E_LD, 0, 0, "ld2");
      cyc(E_LD, 0, 0, "ld3");
      cyc(E_IDLE, 0, 0, "ld_out");
      irq = 4'b1010; irq_mask = 4'b1111;
      cyc(E_IRQ, 1, 1, "irq_a");
      cyc(E_IDLE, 1, 1, "irq_a_idle");
      cyc(E_IDLE, 1, 1, "irq_blocked");
      irq = 4'b1000; id_cmd = 5;
      cyc(E_RET, 0, 1, "ret_a");
      id_cmd = 0; cyc(E_IDLE, 0, 1, "ret_a_idle");
      cyc(E_IRQ, 1, 3, "irq_b");
      irq = 0; cyc(E_IDLE, 1, 3, "irq_b_idle");
      id_cmd = 5; cyc(E_RET, 0, 3, "ret_b");
      id_cmd = 0; irq = 4'b0001; irq_mask = 4'b0000;
      cyc(E_IDLE, 0, 3, "masked0");
      cyc(E_IDLE, 0, 3, "masked1");
      irq_mask = 4'b0001; cyc(E_IRQ, 1, 0, "unmask_irq");
      irq = 0; cyc(E_IDLE, 1, 0, "unmask_idle");
      id_cmd = 5; cyc(E_RET, 0, 0, "ret_c");
      id_cmd = 4; irq_mask = 4'b1111; cyc(E_IDLE, 0, 0, "ret_c_idle");
      cyc(E_LD, 0, 0, "ldi_in");
      id_cmd = 0; irq = 4'b0100;
      cyc(E_LD, 0, 0, "ldi2");
      cyc(E_LD, 0, 0, "ldi3");
      id_cmd = 3; cyc(E_IDLE, 0, 0, "ldi_out");
      cyc(E_IRQ, 1, 2, "ldi_irq_prio");
      id_cmd = 0; irq = 0; cyc(E_IDLE, 1, 2, "ldi_idle");
      id_cmd = 5; cyc(E_RET, 0, 2, "ret_d");
      id_cmd = 3; cyc(E_IDLE, 0, 2, "ret_d_idle");
      cyc(E_MUL, 0, 2, "rmul_in");
      id_cmd = 0;
      for (int i = 1; i < 10; i++) cyc(E_MUL, 0, 2, "rmul");
      rst = 1; pause = 1; cyc(E_RST, 0, 0, "rst_mul");
      rst = 0; pause = 0; id_cmd = 3; cyc(E_IDLE, 0, 0, "rst_mul_idle");
      cyc(E_MUL, 0, 0, "cnt_clr_in");
      id_cmd = 0;
      for (int i = 1; i < 33; i++) cyc(E_MUL, 0, 0, "cnt_clr");
      cyc(E_IDLE, 0, 0, "cnt_clr_out");
      irq = 4'b0010; cyc(E_IRQ, 1, 1, "irq_e");
      cyc(E_IDLE, 1, 1, "irq_e_idle");
      rst = 1; cyc(E_RST, 0, 0, "rst_irq");
      rst = 0; irq = 0; cyc(E_IDLE, 0, 0, "rst_irq_idle");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
